hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order pipeline. It tracks every in-flight register write in a DEPTH-slot shift register aligned with the E..WB stages. It compares the decode-stage source registers against those slots and drives stall, flush and optional forwarding-select controls for the F/D/E pipeline registers. It is the generalised replacement for the fixed 5-stage, 2-source hazard logic and adds load-use detection, downstream hold, forwarding and a stall counter.

---
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: tracks in-flight register writes in DEPTH slots (E..WB).
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_scoreboard #(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned RD_PORTS  = 2,
    parameter int unsigned SEL_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic                         wr_load,
    input  logic                         jumping,
    input  logic                         pipe_hold,
    output logic                         stall_F,
    output logic                         stall_D,
    output logic                         flush_D,
    output logic                         flush_E,
    output logic [RD_PORTS*SEL_W-1:0]    fwd_sel,
    output logic [15:0]                  stall_cnt
);

    if ((64'd1 << ADDR_W) < 64'(REG_COUNT)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for REG_COUNT");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end

    // Index s holds pipeline slot s+1 (index 0 = E, index DEPTH-1 = WB).
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DEPTH-1:0]  load_q, load_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              hazard;
    logic [RD_PORTS*SEL_W-1:0] fwd_raw;

    // The WB slot never matches (write-before-read) and load is only consulted in slot 1.
    logic unused_slot_state;
    assign unused_slot_state = valid_q[DEPTH-1] ^ (^addr_q[DEPTH-1]) ^ (^load_q);

    always_comb begin
        logic [ADDR_W-1:0] src;
        hazard  = 1'b0;
        fwd_raw = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            src = rd_addr[p*ADDR_W +: ADDR_W];
            // Walk oldest to youngest so the youngest match is the one left in fwd_raw.
            for (int s = int'(DEPTH) - 2; s >= 0; s--) begin
                if (valid_q[s] && (addr_q[s] == src) && rd_en[p] && (src != '0)) begin
`ifdef HAZARD_FWD_EN
                    if (s == 0 && load_q[0]) hazard = 1'b1;
                    fwd_raw[p*SEL_W +: SEL_W] = SEL_W'(s + 1);
`else
                    hazard = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        valid_d = valid_q;
        load_d  = load_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (!reset) begin
            if (pipe_hold) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
            end else begin
                for (int s = 1; s < int'(DEPTH); s++) begin
                    valid_d[s] = valid_q[s-1];
                    addr_d[s]  = addr_q[s-1];
                    load_d[s]  = load_q[s-1];
                end
                valid_d[0] = 1'b0;
                addr_d[0]  = wr_addr;
                load_d[0]  = wr_load;
                if (jumping) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (hazard) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end else begin
                    valid_d[0] = wr_en && (wr_addr != '0);
                end
            end
        end
    end

`ifdef HAZARD_FWD_EN
    assign fwd_sel = (reset || pipe_hold || jumping || hazard) ? '0 : fwd_raw;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_raw;
    assign fwd_sel    = '0;
`endif

    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
            for (int s = 0; s < int'(DEPTH); s++) addr_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=3); covers both HAZARD_FWD_EN builds.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        wr_load;
    logic        jumping;
    logic        pipe_hold;
    logic        stall_F, stall_D, flush_D, flush_E;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_load   (wr_load),
        .jumping   (jumping),
        .pipe_hold (pipe_hold),
        .stall_F   (stall_F),
        .stall_D   (stall_D),
        .flush_D   (flush_D),
        .flush_E   (flush_E),
        .fwd_sel   (fwd_sel),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {stall_F, stall_D, flush_D, flush_E}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, stall_F, stall_D, flush_D, flush_E}, {28'd0, exp});
    endtask

    task automatic drv(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic wl,
                       input logic jmp, input logic hold);
        rd_en     = re;
        rd_addr   = {a1, a0};
        wr_en     = we;
        wr_addr   = wa;
        wr_load   = wl;
        jumping   = jmp;
        pipe_hold = hold;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_fwd", {28'd0, fwd_sel}, 32'd0);
        chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        tick();
        reset = 1'b0;

`ifndef HAZARD_FWD_EN
        // Produce x5, then consume it back to back: two stall cycles.
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk_ctl("prod_x5_ctl", 4'b0000);
        tick();
        drv(2'b01, 5'd5, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        chk_ctl("raw_stall1", 4'b1101);
        chk("raw_fwd_zero", {28'd0, fwd_sel}, 32'd0);
        tick();
        chk("cnt_after1", {16'd0, stall_cnt}, 32'd1);
        chk_ctl("raw_stall2", 4'b1101);
        tick();
        chk("cnt_after2", {16'd0, stall_cnt}, 32'd2);
        chk_ctl("raw_release", 4'b0000);
        tick();

        // x6 now in slot 1; jump wins over the port-1 hazard and squashes the x9 write.
        drv(2'b10, 5'd0, 5'd6, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        chk_ctl("jump_ctl", 4'b0011);
        tick();
        chk("jump_cnt", {16'd0, stall_cnt}, 32'd2);
        drv(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("jump_slot1_invalid", 4'b0000);
        drv(2'b10, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("jump_x6_slot2", 4'b1101);
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();

        // x5 in slot 1; hold for three cycles (one with a jump) keeps everything frozen.
        drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_ctl("hold1_ctl", 4'b1100);
        tick();
        drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_ctl("hold2_jump_ctl", 4'b1100);
        tick();
        drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_ctl("hold3_ctl", 4'b1100);
        tick();
        chk("hold_cnt", {16'd0, stall_cnt}, 32'd2);
        drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("post_hold_stall", 4'b1101);
        tick();
        chk("post_hold_cnt", {16'd0, stall_cnt}, 32'd3);
        chk_ctl("post_hold_stall2", 4'b1101);

        // Asynchronous reset in the middle of the stall.
        #2;
        reset = 1'b1;
        #1;
        chk_ctl("midreset_ctl", 4'b0000);
        chk("midreset_cnt", {16'd0, stall_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("after_reset_no_x5", 4'b0000);

        // x0 is never tracked.
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("x0_no_stall", 4'b0000);
        chk("x0_cnt", {16'd0, stall_cnt}, 32'd0);
`else
        // Non-load x7 forwards from slot 1, then slot 2.
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk_ctl("prod_x7_ctl", 4'b0000);
        tick();
        drv(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("fwd1_ctl", 4'b0000);
        chk("fwd1_sel", {28'd0, fwd_sel}, 32'h1);
        tick();
        drv(2'b10, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("fwd2_sel_p1", {28'd0, fwd_sel}, 32'h8);
        tick();
        chk("fwd_wb_none", {28'd0, fwd_sel}, 32'h0);

        // Load x3 then use: one stall, then forward from slot 2.
        drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctl("loaduse_stall", 4'b1101);
        chk("loaduse_fwd0", {28'd0, fwd_sel}, 32'h0);
        tick();
        chk("loaduse_cnt", {16'd0, stall_cnt}, 32'd1);
        chk_ctl("loaduse_release", 4'b0000);
        chk("loaduse_fwd2", {28'd0, fwd_sel}, 32'h2);

        // Jump zeroes forwarding; hold wins over jump.
        drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_ctl("jump_ctl", 4'b0011);
        chk("jump_fwd0", {28'd0, fwd_sel}, 32'h0);
        drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_ctl("hold_jump_ctl", 4'b1100);

        #1;
        reset = 1'b1;
        #1;
        chk_ctl("midreset_ctl", 4'b0000);
        chk("midreset_cnt", {16'd0, stall_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("after_reset_fwd", {28'd0, fwd_sel}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
